// File: rtl/i2c_target_responder.sv
// I2C target with a 4-byte pointer/auto-increment register space; oversamples SCL/SDA and drives SDA open-drain.
// Optional I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter (input latency 5 instead of 3 cycles).
module i2c_target_responder #(
  parameter logic [6:0] ADDRESS = 7'h48,
  parameter int         LENGTH  = 8
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              SCL,
  inout  wire               SDA,
  output logic [1:0]        RegAddr,
  output logic [LENGTH-1:0] RegWrData,
  output logic              RegWrite,
  input  logic [LENGTH-1:0] RegRdData,
  output logic              Busy
);

  localparam logic [3:0] FULL = 4'(LENGTH);
  localparam logic [3:0] LAST = 4'(LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t            state;
  logic [1:0]        sclSync, sdaSync;
  logic              sclIn, sdaIn, sclPrev, sdaPrev;
  logic [3:0]        bitCnt;
  logic [LENGTH-1:0] shiftReg;
  logic              firstByte, sdaOe;

  // Bus idles high, so the synchronizers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sclSync <= 2'b11;
      sdaSync <= 2'b11;
    end else begin
      sclSync <= {sclSync[0], SCL};
      sdaSync <= {sdaSync[0], SDA};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] sclWin, sdaWin;
  logic       sclFilt, sdaFilt;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sclWin  <= 2'b11;
      sdaWin  <= 2'b11;
      sclFilt <= 1'b1;
      sdaFilt <= 1'b1;
    end else begin
      sclWin  <= {sclWin[0], sclSync[1]};
      sdaWin  <= {sdaWin[0], sdaSync[1]};
      sclFilt <= (sclSync[1] & sclWin[0]) | (sclSync[1] & sclWin[1]) | (sclWin[0] & sclWin[1]);
      sdaFilt <= (sdaSync[1] & sdaWin[0]) | (sdaSync[1] & sdaWin[1]) | (sdaWin[0] & sdaWin[1]);
    end
  end

  assign sclIn = sclFilt;
  assign sdaIn = sdaFilt;
`else
  assign sclIn = sclSync[1];
  assign sdaIn = sdaSync[1];
`endif

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclPrev <= sclIn;
      sdaPrev <= sdaIn;
    end
  end

  logic              sclRise, sclFall, sclHigh, startDet, stopDet;
  logic [LENGTH-1:0] shiftIn;

  assign sclRise  = sclIn & ~sclPrev;
  assign sclFall  = ~sclIn & sclPrev;
  // SCL steady high across both samples, so a same-cycle SCL edge never yields START/STOP.
  assign sclHigh  = sclIn & sclPrev;
  assign startDet = sclHigh & sdaPrev & ~sdaIn;
  assign stopDet  = sclHigh & ~sdaPrev & sdaIn;
  assign shiftIn  = {shiftReg[LENGTH-2:0], sdaIn};

  // Flop-driven enable; its async reset releases the bus immediately.
  assign SDA = sdaOe ? 1'b0 : 1'bz;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      firstByte <= 1'b0;
      sdaOe     <= 1'b0;
      RegAddr   <= '0;
      RegWrData <= '0;
      RegWrite  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      // RegAddr doubles as the pointer; it steps the cycle after a write strobe.
      if (RegWrite) RegAddr <= RegAddr + 2'd1;

      if (startDet) begin
        state  <= ADDR;
        bitCnt <= '0;
        Busy   <= 1'b1;
        sdaOe  <= 1'b0;
      end else if (stopDet) begin
        state <= IDLE;
        Busy  <= 1'b0;
        sdaOe <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (sclRise && bitCnt != FULL) begin
              shiftReg <= shiftIn;
              bitCnt   <= bitCnt + 4'd1;
            end else if (sclFall && bitCnt == FULL) begin
              if (shiftReg[LENGTH-1:1] == ADDRESS) begin
                state <= ADDR_ACK;
                sdaOe <= 1'b1;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (sclFall) begin
              bitCnt <= '0;
              if (shiftReg[0]) begin
                state    <= RD_BYTE;
                shiftReg <= RegRdData;
                sdaOe    <= ~RegRdData[LENGTH-1];
              end else begin
                state     <= WR_BYTE;
                firstByte <= 1'b1;
                sdaOe     <= 1'b0;
              end
            end
          end
          WR_BYTE: begin
            if (sclRise && bitCnt != FULL) begin
              shiftReg <= shiftIn;
              bitCnt   <= bitCnt + 4'd1;
              if (bitCnt == LAST) begin
                if (firstByte) begin
                  RegAddr <= shiftIn[1:0];
                end else begin
                  RegWrite  <= 1'b1;
                  RegWrData <= shiftIn;
                end
              end
            end else if (sclFall && bitCnt == FULL) begin
              state     <= WR_ACK;
              sdaOe     <= 1'b1;
              firstByte <= 1'b0;
            end
          end
          WR_ACK: begin
            if (sclFall) begin
              state  <= WR_BYTE;
              sdaOe  <= 1'b0;
              bitCnt <= '0;
            end
          end
          RD_BYTE: begin
            if (sclRise && bitCnt != FULL) begin
              bitCnt <= bitCnt + 4'd1;
            end else if (sclFall) begin
              if (bitCnt == FULL) begin
                state <= RD_ACK;
                sdaOe <= 1'b0;
              end else if (bitCnt != 4'd0) begin
                shiftReg <= {shiftReg[LENGTH-2:0], 1'b0};
                sdaOe    <= ~shiftReg[LENGTH-2];
              end
            end
          end
          RD_ACK: begin
            // Pointer steps on the ACK rise so the reload at the next fall sees the new register.
            if (sclRise) begin
              if (sdaIn) state <= WAIT_STOP;
              else       RegAddr <= RegAddr + 2'd1;
            end else if (sclFall) begin
              state    <= RD_BYTE;
              bitCnt   <= '0;
              shiftReg <= RegRdData;
              sdaOe    <= ~RegRdData[LENGTH-1];
            end
          end
          WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
